// File: rtl/sperate_door_sdpram.sv
// ---------------------------------------------------------------------------
// sperate_door_sdpram
//   Simple dual-port RAM (one write port, one read port) on a single clock,
//   used as a sample buffer between producer and consumer audio stages.
//   The read path is pipelined: a registered array read (rd_q), then an
//   optional output register.
//
// Parameters
//   WR_ADDR_WIDTH  write address width, depth = 2**WR_ADDR_WIDTH
//   WR_DATA_WIDTH  write data width
//   RD_ADDR_WIDTH  read address width  (must equal WR_ADDR_WIDTH)
//   RD_DATA_WIDTH  read data width     (must equal WR_DATA_WIDTH)
//   OUTPUT_REG     1: two-cycle read latency, 0: one-cycle read latency
//
// Ports
//   clk      rising-edge clock shared by both ports
//   rst_n    async active-low reset, clears the read pipeline only
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address, sampled every cycle (no read enable)
//   rd_data  read data
// ---------------------------------------------------------------------------
module sperate_door_sdpram #(
  parameter int WR_ADDR_WIDTH = 10,
  parameter int WR_DATA_WIDTH = 16,
  parameter int RD_ADDR_WIDTH = 10,
  parameter int RD_DATA_WIDTH = 16,
  parameter int OUTPUT_REG    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
  output logic [RD_DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** WR_ADDR_WIDTH;

  logic [WR_DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [RD_DATA_WIDTH-1:0] rd_q;

  // Storage has no reset so it maps onto block RAM; writes are accepted
  // regardless of rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-first: on a same-address collision this samples the array before
  // the write above lands, so the old contents are returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[rd_addr];
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data <= '0;
        end else begin
          rd_data <= rd_q;
        end
      end
    end else begin : g_no_out_reg
      assign rd_data = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_sperate_door_sdpram.sv
// ---------------------------------------------------------------------------
// tb_sperate_door_sdpram
//   Randomized scoreboard bench for sperate_door_sdpram (default params).
//   The driver keeps a plain array model of memory; each checked read pushes
//   the model value (taken before that cycle's write, i.e. read-first) with
//   the cycle on which it must appear. The monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_sperate_door_sdpram;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data;

  sperate_door_sdpram dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [1024];
  bit          known [1024];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: rd_data=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: zero while in reset, otherwise compare whatever is due now.
  always @(negedge clk) begin
    if (rst_n === 1'b0) begin
      check("reset_zero", rd_data, 16'h0000);
    end else begin
      while (sb.size() != 0 && sb[0].due < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL stale_%s: entry due cycle %0d not checked, now %0d", sb[0].tag, sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() != 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check(e.tag, rd_data, e.val);
      end
    end
  end

  // One cycle of stimulus, driven just after the falling edge.
  task automatic issue(input bit we, input int wa, input int wd, input int ra,
                       input bit chk, input string tag);
    exp_t e;
    @(negedge clk);
    wr_en   = we;
    wr_addr = wa[9:0];
    wr_data = wd[15:0];
    rd_addr = ra[9:0];
    if (chk && known[ra[9:0]]) begin
      e.due = cyc + 2;
      e.val = model[ra[9:0]];
      e.tag = tag;
      sb.push_back(e);
    end
    if (we) begin
      model[wa[9:0]] = wd[15:0];
      known[wa[9:0]] = 1'b1;
    end
  endtask

  // Release reset mid-cycle with rd_addr = ra already presented.
  task automatic release_reset(input int ra);
    exp_t e;
    issue(1'b0, 0, 0, ra, 1'b0, "none");
    #2 rst_n = 1'b1;
    #1 check("release_hold", rd_data, 16'h0000);
    e.due = cyc + 1;
    e.val = 16'h0000;
    e.tag = "first_edge_after_release";
    sb.push_back(e);
    if (known[ra[9:0]]) begin
      e.due = cyc + 2;
      e.val = model[ra[9:0]];
      e.tag = "first_read_after_release";
      sb.push_back(e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) known[i] = 1'b0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;

    // 200 ns of reset; writes during reset must still land.
    for (int i = 0; i < 10; i++) issue(1'b1, 900 + i, $urandom, 0, 1'b0, "none");
    for (int i = 0; i < 10; i++) issue(1'b0, 0, 0, 0, 1'b0, "none");
    release_reset(905);
    for (int i = 0; i < 10; i++) issue(1'b0, 0, 0, 900 + i, 1'b1, "write_in_reset");

    // Fill k <- FFFF-k with random reads of already-known addresses alongside.
    for (int k = 0; k < 1024; k++)
      issue(1'b1, k, 16'hFFFF - k, $urandom_range(0, 1023), 1'b1, "fill_rand_read");

    // Sweep readback while wr_en=0 drives junk on the write port.
    for (int k = 0; k < 1024; k++)
      issue(1'b0, $urandom_range(0, 1023), $urandom, k, 1'b1, "sweep");

    // Latency: mem[4]=0000, mem[5]=1234, read 4 then 5.
    issue(1'b1, 5, 16'h1234, 0, 1'b0, "none");
    issue(1'b1, 4, 16'h0000, 0, 1'b0, "none");
    issue(1'b0, 0, 0, 4, 1'b1, "latency_prev");
    issue(1'b0, 0, 0, 5, 1'b1, "latency_addr5");
    issue(1'b0, 0, 0, 5, 1'b1, "latency_addr5_hold");

    // Read-during-write to the same address returns old data.
    issue(1'b1, 7, 16'hAAAA, 0, 1'b0, "none");
    issue(1'b1, 7, 16'h5555, 7, 1'b1, "rdw_old");
    issue(1'b0, 0, 0, 7, 1'b1, "rdw_new");

    // Random mix on a small address window for frequent collisions.
    for (int i = 0; i < 500; i++)
      issue(1'($urandom), $urandom_range(0, 31), $urandom, $urandom_range(0, 31), 1'b1, "random_mix");

    // Reset in the middle of a read sweep.
    for (int i = 0; i < 8; i++) issue(1'b0, 0, 0, i, 1'b1, "pre_reset_sweep");
    #3 rst_n = 1'b0;
    #1 check("reset_async", rd_data, 16'h0000);
    sb.delete();
    for (int i = 0; i < 4; i++) issue(1'b0, 0, 0, 8 + i, 1'b0, "none");
    release_reset(0);
    for (int i = 0; i < 16; i++) issue(1'b0, 0, 0, i, 1'b1, "post_reset_reread");

    // Drain the pipeline.
    for (int i = 0; i < 5; i++) issue(1'b0, 0, 0, 0, 1'b0, "none");
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected reads left unchecked, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
